// File: rtl/service_arbiter.sv
// service_arbiter: owner of the shared UI resources (7-segment display,
// push buttons, service LEDs). It synchronises the service switches,
// debounces the buttons and grants the UI to one of four services at a time.
//
// Optional feature macro: ALARM_PREEMPT_EN
//   defined   : an alarm request takes the UI from any state.
//   undefined : an alarm request is taken only from IDLE or DONE. In ACTIVE
//               or CONFLICT it waits until the FSM next passes through one
//               of those states with the request still high.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no owner, waiting for exactly one service switch
// ACTIVE   | one service owns display, buttons and LEDs
// DONE     | owner reported finish; held until all switches are lowered
// CONFLICT | more than one switch on with no owner; nothing granted
// ALARM    | alarm forces service 4 to own the UI
module service_arbiter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] svc_sw,
  input  logic [4:0] push,
  input  logic [3:0] finish,
  input  logic       alarm_req,
  output logic [3:0] grant,
  output logic [4:0] push_evt,
  output logic [2:0] disp_sel,
  output logic [3:0] svc_led,
  output logic       conflict,
  output logic       alarm_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVE,
    S_DONE,
    S_CONFLICT,
    S_ALARM
  } state_t;

  localparam logic [7:0] DB_TC = 8'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][3:0] sw_sync;
  logic [SYNC_STAGES-1:0][4:0] push_sync;
  logic [3:0]                  s_sw;
  logic [4:0]                  s_push;

  logic [4:0][7:0] db_cnt;
  logic [4:0]      db_lvl;
  logic [4:0]      db_prev;
  logic [4:0]      db_rise;

  state_t     state, state_nxt;
  logic [3:0] owner, owner_nxt;
  logic [3:0] grant_nxt;
  logic [2:0] disp_sel_nxt;
  logic       sw_multi;
  logic       sw_onehot;
  logic       alarm_take;

  assign s_sw      = sw_sync[SYNC_STAGES-1];
  assign s_push    = push_sync[SYNC_STAGES-1];
  assign sw_multi  = ($countones(s_sw) > 1);
  assign sw_onehot = $onehot(s_sw);
  assign db_rise   = db_lvl & ~db_prev;

`ifdef ALARM_PREEMPT_EN
  assign alarm_take = alarm_req;
`else
  // ALARM itself is listed so an ongoing alarm keeps the state while held.
  assign alarm_take = alarm_req &&
                      (state == S_IDLE || state == S_DONE || state == S_ALARM);
`endif

  // Metastability shift chains for the asynchronous switches and buttons.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_sync   <= '0;
      push_sync <= '0;
    end else begin
      sw_sync   <= {sw_sync[SYNC_STAGES-2:0], svc_sw};
      push_sync <= {push_sync[SYNC_STAGES-2:0], push};
    end
  end

  // Per-button debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      db_cnt  <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s_push[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] + 8'd1 == DB_TC) begin
          db_lvl[i] <= ~db_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end
      end
      db_prev <= db_lvl;
    end
  end

  // State and owner registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // Next-state logic; alarm beats finish, finish beats switch changes.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if (alarm_take) begin
      state_nxt = S_ALARM;
      owner_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sw_onehot) begin
            state_nxt = S_ACTIVE;
            owner_nxt = s_sw;
          end else if (sw_multi) begin
            state_nxt = S_CONFLICT;
          end
        end
        S_ACTIVE: begin
          if ((finish & owner) != 4'b0000) begin
            state_nxt = S_DONE;
            owner_nxt = '0;
          end else if ((s_sw & owner) == 4'b0000) begin
            state_nxt = S_IDLE;
            owner_nxt = '0;
          end
        end
        S_DONE: begin
          if (s_sw == 4'b0000) state_nxt = S_IDLE;
        end
        S_CONFLICT: begin
          if (!sw_multi) state_nxt = S_IDLE;
        end
        S_ALARM: begin
          state_nxt = S_IDLE;
          owner_nxt = '0;
        end
        default: begin
          state_nxt = S_IDLE;
          owner_nxt = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs change on the same edge.
  always_comb begin
    grant_nxt    = 4'b0000;
    disp_sel_nxt = 3'd0;
    if (state_nxt == S_ACTIVE) begin
      grant_nxt = owner_nxt;
      case (owner_nxt)
        4'b1000: disp_sel_nxt = 3'd1;
        4'b0100: disp_sel_nxt = 3'd2;
        4'b0010: disp_sel_nxt = 3'd3;
        4'b0001: disp_sel_nxt = 3'd4;
        default: disp_sel_nxt = 3'd0;
      endcase
    end else if (state_nxt == S_ALARM) begin
      grant_nxt    = 4'b0001;
      disp_sel_nxt = 3'd4;
    end
  end

  // Registered outputs; button events only reach a granted service.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant        <= '0;
      push_evt     <= '0;
      disp_sel     <= '0;
      svc_led      <= '0;
      conflict     <= 1'b0;
      alarm_active <= 1'b0;
    end else begin
      grant        <= grant_nxt;
      svc_led      <= grant_nxt;
      disp_sel     <= disp_sel_nxt;
      push_evt     <= (grant_nxt != 4'b0000) ? db_rise : 5'b00000;
      conflict     <= sw_multi;
      alarm_active <= (state_nxt == S_ALARM);
    end
  end

endmodule

// File: tb/tb_service_arbiter.sv
// Testbench for service_arbiter. Expected output vectors are queued with the
// cycle they are due on when stimulus is applied, then popped and compared
// as the cycles elapse. Output vector layout:
//   {grant[3:0], disp_sel[2:0], svc_led[3:0], conflict, alarm_active, push_evt[4:0]}
module tb_service_arbiter;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int SYNC_STAGES     = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] svc_sw;
  logic [4:0] push;
  logic [3:0] finish;
  logic       alarm_req;
  logic [3:0] grant;
  logic [4:0] push_evt;
  logic [2:0] disp_sel;
  logic [3:0] svc_led;
  logic       conflict;
  logic       alarm_active;

  service_arbiter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .svc_sw      (svc_sw),
    .push        (push),
    .finish      (finish),
    .alarm_req   (alarm_req),
    .grant       (grant),
    .push_evt    (push_evt),
    .disp_sel    (disp_sel),
    .svc_led     (svc_led),
    .conflict    (conflict),
    .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [17:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [17:0] obs;

  assign obs = {grant, disp_sel, svc_led, conflict, alarm_active, push_evt};

  function automatic logic [17:0] ov(input logic [3:0] g, input logic [2:0] d,
                                     input logic c, input logic a,
                                     input logic [4:0] e);
    return {g, d, g, c, a, e};
  endfunction

  localparam logic [17:0] ZERO = 18'd0;

  function automatic logic [17:0] act(input logic [3:0] g, input logic [2:0] d,
                                      input logic c);
    return ov(g, d, c, 1'b0, 5'b00000);
  endfunction

  function automatic logic [17:0] alm(input logic [4:0] e);
    return ov(4'b0001, 3'd4, 1'b0, 1'b1, e);
  endfunction

  task automatic expect_at(input int d, input logic [17:0] v, input string nm);
    sb.push_back('{cyc + d, v, nm});
  endtask

  task automatic expect_span(input int d0, input int d1, input logic [17:0] v,
                             input string nm);
    for (int k = d0; k <= d1; k++) sb.push_back('{cyc + k, v, nm});
  endtask

  task automatic test_reset();
    exp_t e;
    resetn = 1'b0; svc_sw = '0; push = '0; finish = '0; alarm_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== ZERO) begin
      n_err++;
      $display("FAIL reset_hold got %b want %b", obs, ZERO);
    end
    resetn = 1'b1;
    expect_span(1, 3, ZERO, "reset_idle");
    repeat (3) begin
      @(posedge clk); #1; cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (obs !== e.val || e.cyc != cyc) begin
          n_err++;
          $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_grant();
    exp_t e;
    svc_sw = 4'b1000;
    expect_span(1, 2, ZERO, "grant_latency");
    expect_span(3, 4, act(4'b1000, 3'd1, 1'b0), "grant_svc1");
    repeat (4) begin
      @(posedge clk); #1; cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front(); n_cmp++;
        if (obs !== e.val || e.cyc != cyc) begin
          n_err++;
          $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
        end
      end
    end
  endtask

  task automatic test_debounce();
    exp_t e;
    // 3-cycle glitch, then a 10-cycle press, then release
    for (int ph = 0; ph < 4; ph++) begin
      int n;
      case (ph)
        0: begin push = 5'b00001; n = 3;
                 expect_span(1, 3, act(4'b1000, 3'd1, 1'b0), "glitch_hi"); end
        1: begin push = 5'b00000; n = 8;
                 expect_span(1, 8, act(4'b1000, 3'd1, 1'b0), "glitch_lo"); end
        2: begin push = 5'b00001; n = 10;
                 expect_span(1, 6, act(4'b1000, 3'd1, 1'b0), "press_wait");
                 expect_at(7, ov(4'b1000, 3'd1, 1'b0, 1'b0, 5'b00001), "press_evt");
                 expect_span(8, 10, act(4'b1000, 3'd1, 1'b0), "press_single"); end
        default: begin push = 5'b00000; n = 10;
                 expect_span(1, 10, act(4'b1000, 3'd1, 1'b0), "release_quiet"); end
      endcase
      repeat (n) begin
        @(posedge clk); #1; cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); n_cmp++;
          if (obs !== e.val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
          end
        end
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    for (int ph = 0; ph < 6; ph++) begin
      int n;
      case (ph)
        0: begin svc_sw = 4'b1010; n = 4;
                 expect_span(1, 2, act(4'b1000, 3'd1, 1'b0), "second_sw_sync");
                 expect_span(3, 4, act(4'b1000, 3'd1, 1'b1), "first_owner_wins"); end
        1: begin svc_sw = 4'b0010; n = 5;
                 expect_span(1, 2, act(4'b1000, 3'd1, 1'b1), "drop_owner_sync");
                 expect_at(3, ZERO, "drop_owner_idle");
                 expect_span(4, 5, act(4'b0010, 3'd3, 1'b0), "handover_svc3"); end
        2: begin svc_sw = 4'b0000; n = 3;
                 expect_span(1, 2, act(4'b0010, 3'd3, 1'b0), "svc3_sync");
                 expect_at(3, ZERO, "svc3_release"); end
        3: begin svc_sw = 4'b0110; n = 4;
                 expect_span(1, 2, ZERO, "idle_conflict_sync");
                 expect_span(3, 4, ov(4'b0000, 3'd0, 1'b1, 1'b0, 5'b0), "conflict_state"); end
        4: begin svc_sw = 4'b0100; n = 5;
                 expect_span(1, 2, ov(4'b0000, 3'd0, 1'b1, 1'b0, 5'b0), "conflict_hold");
                 expect_at(3, ZERO, "conflict_to_idle");
                 expect_span(4, 5, act(4'b0100, 3'd2, 1'b0), "conflict_resolve"); end
        default: begin svc_sw = 4'b0000; n = 3;
                 expect_span(1, 2, act(4'b0100, 3'd2, 1'b0), "svc2_sync");
                 expect_at(3, ZERO, "svc2_release"); end
      endcase
      repeat (n) begin
        @(posedge clk); #1; cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); n_cmp++;
          if (obs !== e.val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
          end
        end
      end
    end
  endtask

  task automatic test_done();
    exp_t e;
    for (int ph = 0; ph < 6; ph++) begin
      int n;
      case (ph)
        0: begin svc_sw = 4'b0100; n = 3;
                 expect_span(1, 2, ZERO, "svc2_sync");
                 expect_at(3, act(4'b0100, 3'd2, 1'b0), "svc2_active"); end
        1: begin finish = 4'b0100; n = 1;
                 expect_at(1, ZERO, "finish_done"); end
        2: begin finish = 4'b0000; n = 4;
                 expect_span(1, 4, ZERO, "done_blocks_reentry"); end
        3: begin svc_sw = 4'b0000; n = 3;
                 expect_span(1, 3, ZERO, "done_to_idle"); end
        4: begin svc_sw = 4'b0001; n = 3;
                 expect_span(1, 2, ZERO, "svc4_sync");
                 expect_at(3, act(4'b0001, 3'd4, 1'b0), "svc4_after_done"); end
        default: begin svc_sw = 4'b0000; n = 3;
                 expect_span(1, 2, act(4'b0001, 3'd4, 1'b0), "svc4_sync_off");
                 expect_at(3, ZERO, "svc4_release"); end
      endcase
      repeat (n) begin
        @(posedge clk); #1; cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); n_cmp++;
          if (obs !== e.val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
          end
        end
      end
    end
  endtask

  task automatic test_alarm();
    exp_t e;
    for (int ph = 0; ph < 5; ph++) begin
      int n;
      case (ph)
        0: begin svc_sw = 4'b0010; n = 3;
                 expect_span(1, 2, ZERO, "svc3_sync");
                 expect_at(3, act(4'b0010, 3'd3, 1'b0), "svc3_active"); end
        1: begin alarm_req = 1'b1; n = 3;
`ifdef ALARM_PREEMPT_EN
                 expect_span(1, 3, alm(5'b0), "alarm_preempt");
`else
                 expect_span(1, 3, act(4'b0010, 3'd3, 1'b0), "alarm_pending");
`endif
           end
        2: begin svc_sw = 4'b0000; n = 4;
`ifdef ALARM_PREEMPT_EN
                 expect_span(1, 4, alm(5'b0), "alarm_ignores_sw");
`else
                 expect_span(1, 2, act(4'b0010, 3'd3, 1'b0), "pending_sync");
                 expect_at(3, ZERO, "pending_idle");
                 expect_at(4, alm(5'b0), "pending_alarm");
`endif
           end
        3: begin finish = 4'b0001; n = 3;
                 expect_span(1, 3, alm(5'b0), "alarm_ignores_finish"); end
        default: begin alarm_req = 1'b0; finish = 4'b0000; n = 2;
                 expect_span(1, 2, ZERO, "alarm_exit"); end
      endcase
      repeat (n) begin
        @(posedge clk); #1; cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); n_cmp++;
          if (obs !== e.val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_alarm();
    exp_t e;
    for (int ph = 0; ph < 3; ph++) begin
      int n;
      case (ph)
        0: begin alarm_req = 1'b1; push = 5'b00010; n = 10;
                 expect_span(1, 6, alm(5'b0), "alarm_press_wait");
                 expect_at(7, alm(5'b00010), "alarm_press_evt");
                 expect_span(8, 10, alm(5'b0), "alarm_press_single"); end
        1: begin
                 resetn = 1'b0;
                 #1;
                 n_cmp++;
                 if (obs !== ZERO) begin
                   n_err++;
                   $display("FAIL reset_async got %b want %b", obs, ZERO);
                 end
                 @(posedge clk); #1;
                 n_cmp++;
                 if (obs !== ZERO) begin
                   n_err++;
                   $display("FAIL reset_held got %b want %b", obs, ZERO);
                 end
                 resetn = 1'b1; n = 8;
                 expect_span(1, 6, alm(5'b0), "post_reset_no_evt");
                 expect_at(7, alm(5'b00010), "post_reset_evt");
                 expect_at(8, alm(5'b0), "post_reset_single");
           end
        default: begin alarm_req = 1'b0; push = 5'b00000; n = 3;
                 expect_span(1, 3, ZERO, "final_idle"); end
      endcase
      repeat (n) begin
        @(posedge clk); #1; cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front(); n_cmp++;
          if (obs !== e.val || e.cyc != cyc) begin
            n_err++;
            $display("FAIL %s cyc=%0d got %b want %b", e.name, cyc, obs, e.val);
          end
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_grant();
    test_debounce();
    test_conflict();
    test_done();
    test_alarm();
    test_reset_mid_alarm();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
